udt_pkt_dispatch: RTL and testbench

Parametrised UDT receive-side packet dispatcher sitting between the UDP receive path (after keep realignment) and the UDT protocol engines, generalising the fixed 64-bit type decoder. Classifies each incoming packet from its first beat into the data class, an accepted control type, or drop, then forwards the whole packet on a dedicated AXI-Stream port with per-packet sideband. Drops malformed and unaccepted packets and keeps saturating per-class statistics counters.

---
 rtl/udt_pkt_dispatch.sv | 162 ++++++++++++++++
 tb/tb_udt_pkt_dispatch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udt_pkt_dispatch.sv
// UDT receive-side packet dispatcher: classifies each packet from its first beat
// and forwards it to the data or control stream, or drops it, with saturating counters.
module udt_pkt_dispatch #(
   parameter int unsigned DATA_W    = 64,
   parameter logic [15:0] CTRL_MASK = 16'h00EF,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                core_clk,
   input  logic                core_rst,
   input  logic [DATA_W-1:0]   in_tdata,
   input  logic [DATA_W/8-1:0] in_tkeep,
   input  logic                in_tvalid,
   input  logic                in_tlast,
   output logic                in_tready,
   output logic [DATA_W-1:0]   data_tdata,
   output logic [DATA_W/8-1:0] data_tkeep,
   output logic                data_tvalid,
   output logic                data_tlast,
   input  logic                data_tready,
   output logic [30:0]         data_seq,
   output logic [DATA_W-1:0]   ctrl_tdata,
   output logic [DATA_W/8-1:0] ctrl_tkeep,
   output logic                ctrl_tvalid,
   output logic                ctrl_tlast,
   input  logic                ctrl_tready,
   output logic [14:0]         ctrl_type,
   input  logic                clr_cnt,
   output logic [CNT_W-1:0]    cnt_data,
   output logic [CNT_W-1:0]    cnt_ctrl,
   output logic [CNT_W-1:0]    cnt_drop
);

   typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTRL, DROP} state_t;
   typedef enum logic [1:0] {CLS_DATA, CLS_CTRL, CLS_DROP} cls_t;

   state_t      state;
   state_t      fwd_state;
   cls_t        first_cls;
   cls_t        beat_cls;
   logic [31:0] hdr;
   logic [14:0] hdr_type;
   logic        data_free;
   logic        ctrl_free;
   logic        ready_raw;
   logic        accept;
   logic        first;

   // Header arrives in network byte order: byte 0 is the MSB.
   assign hdr      = {in_tdata[7:0], in_tdata[15:8], in_tdata[23:16], in_tdata[31:24]};
   assign hdr_type = hdr[30:16];

   assign data_free = !data_tvalid || data_tready;
   assign ctrl_free = !ctrl_tvalid || ctrl_tready;
   assign first     = (state == IDLE);
   assign accept    = in_tvalid && in_tready;

   always_comb begin
      first_cls = CLS_DROP;
      if (in_tkeep[3:0] != 4'hF)
         first_cls = CLS_DROP;
      else if (!hdr[31])
         first_cls = CLS_DATA;
      else if ((hdr_type < 15'd16) && CTRL_MASK[hdr_type[3:0]])
         first_cls = CLS_CTRL;
   end

   always_comb begin
      beat_cls = first_cls;
      case (state)
         FWD_DATA: beat_cls = CLS_DATA;
         FWD_CTRL: beat_cls = CLS_CTRL;
         DROP:     beat_cls = CLS_DROP;
         default:  beat_cls = first_cls;
      endcase
   end

   always_comb begin
      fwd_state = DROP;
      case (beat_cls)
         CLS_DATA: fwd_state = FWD_DATA;
         CLS_CTRL: fwd_state = FWD_CTRL;
         default:  fwd_state = DROP;
      endcase
   end

   // Ready depends only on state and output occupancy, never on the incoming beat.
   always_comb begin
      ready_raw = 1'b0;
      case (state)
         IDLE:     ready_raw = data_free && ctrl_free;
         FWD_DATA: ready_raw = data_free;
         FWD_CTRL: ready_raw = ctrl_free;
         DROP:     ready_raw = 1'b1;
         default:  ready_raw = 1'b0;
      endcase
   end

   assign in_tready = !core_rst && ready_raw;

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         state       <= IDLE;
         data_tdata  <= '0;
         data_tkeep  <= '0;
         data_tvalid <= 1'b0;
         data_tlast  <= 1'b0;
         data_seq    <= '0;
         ctrl_tdata  <= '0;
         ctrl_tkeep  <= '0;
         ctrl_tvalid <= 1'b0;
         ctrl_tlast  <= 1'b0;
         ctrl_type   <= '0;
      end else begin
         if (data_tready)
            data_tvalid <= 1'b0;
         if (ctrl_tready)
            ctrl_tvalid <= 1'b0;
         if (accept) begin
            case (beat_cls)
               CLS_DATA: begin
                  data_tdata  <= in_tdata;
                  data_tkeep  <= in_tkeep;
                  data_tlast  <= in_tlast;
                  data_tvalid <= 1'b1;
                  if (first)
                     data_seq <= hdr[30:0];
               end
               CLS_CTRL: begin
                  ctrl_tdata  <= in_tdata;
                  ctrl_tkeep  <= in_tkeep;
                  ctrl_tlast  <= in_tlast;
                  ctrl_tvalid <= 1'b1;
                  if (first)
                     ctrl_type <= hdr_type;
               end
               default: ;
            endcase
            state <= in_tlast ? IDLE : fwd_state;
         end
      end
   end

   // Clear has priority; an increment coinciding with it is discarded.
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         cnt_data <= '0;
         cnt_ctrl <= '0;
         cnt_drop <= '0;
      end else if (clr_cnt) begin
         cnt_data <= '0;
         cnt_ctrl <= '0;
         cnt_drop <= '0;
      end else if (accept && first) begin
         case (first_cls)
            CLS_DATA: if (cnt_data != '1) cnt_data <= cnt_data + CNT_W'(1);
            CLS_CTRL: if (cnt_ctrl != '1) cnt_ctrl <= cnt_ctrl + CNT_W'(1);
            default:  if (cnt_drop != '1) cnt_drop <= cnt_drop + CNT_W'(1);
         endcase
      end
   end

endmodule

// File: tb/tb_udt_pkt_dispatch.sv
// Directed bench for udt_pkt_dispatch: a reference classifier pushes expected output
// beats into per-port queues that are popped on each output handshake.
module tb_udt_pkt_dispatch;

   localparam logic [15:0] MASK = 16'h00EF;

   logic        core_clk = 1'b0;
   logic        core_rst;
   logic [63:0] in_tdata;
   logic [7:0]  in_tkeep;
   logic        in_tvalid;
   logic        in_tlast;
   logic        in_tready;
   logic [63:0] data_tdata;
   logic [7:0]  data_tkeep;
   logic        data_tvalid;
   logic        data_tlast;
   logic        data_tready;
   logic [30:0] data_seq;
   logic [63:0] ctrl_tdata;
   logic [7:0]  ctrl_tkeep;
   logic        ctrl_tvalid;
   logic        ctrl_tlast;
   logic        ctrl_tready;
   logic [14:0] ctrl_type;
   logic        clr_cnt;
   logic [3:0]  cnt_data;
   logic [3:0]  cnt_ctrl;
   logic [3:0]  cnt_drop;

   always #5 core_clk = ~core_clk;

   udt_pkt_dispatch #(.DATA_W(64), .CTRL_MASK(MASK), .CNT_W(4)) dut (
      .core_clk(core_clk), .core_rst(core_rst),
      .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid),
      .in_tlast(in_tlast), .in_tready(in_tready),
      .data_tdata(data_tdata), .data_tkeep(data_tkeep), .data_tvalid(data_tvalid),
      .data_tlast(data_tlast), .data_tready(data_tready), .data_seq(data_seq),
      .ctrl_tdata(ctrl_tdata), .ctrl_tkeep(ctrl_tkeep), .ctrl_tvalid(ctrl_tvalid),
      .ctrl_tlast(ctrl_tlast), .ctrl_tready(ctrl_tready), .ctrl_type(ctrl_type),
      .clr_cnt(clr_cnt), .cnt_data(cnt_data), .cnt_ctrl(cnt_ctrl), .cnt_drop(cnt_drop)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic [30:0] s;
   } beat_t;

   beat_t dq[$];
   beat_t cq[$];

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state: 0 idle, 1 data, 2 ctrl, 3 drop
   int          m_state = 0;
   logic [30:0] m_seq   = '0;
   logic [14:0] m_type  = '0;
   int          e_data  = 0;
   int          e_ctrl  = 0;
   int          e_drop  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [31:0] h, input logic [31:0] rest);
      return {rest, h[7:0], h[15:8], h[23:16], h[31:24]};
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= 15) ? 15 : v + 1;
   endfunction

   task automatic model_accept(input logic [63:0] d, input logic [7:0] k, input logic l);
      logic [31:0] h;
      int          cls;
      h   = {d[7:0], d[15:8], d[23:16], d[31:24]};
      cls = m_state;
      if (m_state == 0) begin
         if (k[3:0] != 4'hF) cls = 3;
         else if (h[31] == 1'b0) begin cls = 1; m_seq = h[30:0]; end
         else if (h[30:16] < 15'd16 && MASK[h[19:16]]) begin cls = 2; m_type = h[30:16]; end
         else cls = 3;
         if (clr_cnt) begin
            e_data = 0; e_ctrl = 0; e_drop = 0;
         end else if (cls == 1) e_data = sat_inc(e_data);
         else if (cls == 2) e_ctrl = sat_inc(e_ctrl);
         else e_drop = sat_inc(e_drop);
      end else if (clr_cnt) begin
         e_data = 0; e_ctrl = 0; e_drop = 0;
      end
      if (cls == 1) begin
         dq.push_back({d, k, l, m_seq});
         check("data_latency", 64'(data_tvalid), 64'd1);
      end else if (cls == 2) begin
         cq.push_back({d, k, l, {16'd0, m_type}});
         check("ctrl_latency", 64'(ctrl_tvalid), 64'd1);
      end
      m_state = l ? 0 : cls;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            output int waited);
      bit rdy;
      rdy    = 1'b0;
      waited = 0;
      in_tdata  = d;
      in_tkeep  = k;
      in_tlast  = l;
      in_tvalid = 1'b1;
      while (!rdy && waited < 200) begin
         @(negedge core_clk);
         rdy = in_tready;
         @(posedge core_clk);
         #1;
         if (!rdy) waited++;
      end
      in_tvalid = 1'b0;
      if (!rdy) check("accept_timeout", 64'(rdy), 64'd1);
      else model_accept(d, k, l);
   endtask

   task automatic check_cnt(input string tag);
      check({tag, "_cnt_data"}, 64'(cnt_data), 64'(e_data));
      check({tag, "_cnt_ctrl"}, 64'(cnt_ctrl), 64'(e_ctrl));
      check({tag, "_cnt_drop"}, 64'(cnt_drop), 64'(e_drop));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge core_clk);
         #1;
      end
   endtask

   // Output monitor: a beat visible with tready at the falling edge is taken at the next rise.
   always @(negedge core_clk) begin
      beat_t e;
      if (!core_rst) begin
         if (data_tvalid && data_tready) begin
            if (dq.size() == 0) check("data_unexpected_beat", 64'(dq.size()), 64'd1);
            else begin
               e = dq.pop_front();
               check("data_tdata", data_tdata, e.d);
               check("data_tkeep", 64'(data_tkeep), 64'(e.k));
               check("data_tlast", 64'(data_tlast), 64'(e.l));
               check("data_seq", 64'(data_seq), 64'(e.s));
            end
         end
         if (ctrl_tvalid && ctrl_tready) begin
            if (cq.size() == 0) check("ctrl_unexpected_beat", 64'(cq.size()), 64'd1);
            else begin
               e = cq.pop_front();
               check("ctrl_tdata", ctrl_tdata, e.d);
               check("ctrl_tkeep", 64'(ctrl_tkeep), 64'(e.k));
               check("ctrl_tlast", 64'(ctrl_tlast), 64'(e.l));
               check("ctrl_type", 64'(ctrl_type), 64'(e.s));
            end
         end
      end
   end

   initial begin
      int          w;
      int          types[7];
      logic [63:0] b1;
      logic [63:0] b2;
      types = '{0, 1, 2, 3, 5, 6, 7};

      core_rst    = 1'b1;
      in_tdata    = '0;
      in_tkeep    = '0;
      in_tvalid   = 1'b0;
      in_tlast    = 1'b0;
      data_tready = 1'b1;
      ctrl_tready = 1'b1;
      clr_cnt     = 1'b0;

      #12;
      check("rst_in_tready", 64'(in_tready), 64'd0);
      check("rst_data_tvalid", 64'(data_tvalid), 64'd0);
      check("rst_ctrl_tvalid", 64'(ctrl_tvalid), 64'd0);
      check("rst_data_tdata", data_tdata, 64'd0);
      check("rst_ctrl_tlast", 64'(ctrl_tlast), 64'd0);
      check("rst_data_seq", 64'(data_seq), 64'd0);
      check("rst_ctrl_type", 64'(ctrl_type), 64'd0);
      check_cnt("rst");
      @(posedge core_clk);
      #1 core_rst = 1'b0;
      #1 check("post_rst_in_tready", 64'(in_tready), 64'd1);

      // 3-beat data packet
      send_beat(mk(32'h0000_1234, 32'hA1A2_A3A4), 8'hFF, 1'b0, w);
      send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, w);
      send_beat(64'h5555_6666_7777_8888, 8'h0F, 1'b1, w);
      idle_cycles(3);
      check("data_seq_1234", 64'(data_seq), 64'h1234);
      check_cnt("data3");

      // ACK packet, type 2
      send_beat(mk(32'h8002_0000, 32'hC0FF_EE00), 8'hFF, 1'b0, w);
      send_beat(64'hDEAD_BEEF_0BAD_F00D, 8'h3F, 1'b1, w);
      idle_cycles(3);
      check("ctrl_type_2", 64'(ctrl_type), 64'd2);
      check_cnt("ack");

      // Type 4 is masked off: four beats consumed without stalls, then a 1-beat data packet
      send_beat(mk(32'h8004_0000, 32'h0), 8'hFF, 1'b0, w);
      check("drop_ready_0", 64'(w), 64'd0);
      for (int i = 0; i < 3; i++) begin
         send_beat({$urandom, $urandom}, 8'hFF, (i == 2), w);
         check("drop_ready", 64'(w), 64'd0);
      end
      send_beat(mk(32'h0000_0042, 32'h1357_9BDF), 8'hFF, 1'b1, w);
      idle_cycles(3);
      check("data_seq_42", 64'(data_seq), 64'h42);
      check_cnt("drop4");

      // Type 16 and type 15 are both dropped
      send_beat(mk(32'h8010_0000, 32'h0), 8'hFF, 1'b1, w);
      send_beat(mk(32'h800F_0000, 32'h0), 8'hFF, 1'b1, w);
      idle_cycles(2);
      check_cnt("drop_types");

      // Backpressure for 5 cycles mid-packet
      b1 = mk(32'h0000_5555, 32'h9999_AAAA);
      send_beat(b1, 8'hFF, 1'b0, w);
      data_tready = 1'b0;
      b2 = 64'h0102_0304_0506_0708;
      in_tdata  = b2;
      in_tkeep  = 8'hFF;
      in_tlast  = 1'b0;
      in_tvalid = 1'b1;
      repeat (5) begin
         @(negedge core_clk);
         check("bp_in_tready", 64'(in_tready), 64'd0);
         check("bp_data_held", data_tdata, b1);
         check("bp_data_tvalid", 64'(data_tvalid), 64'd1);
         @(posedge core_clk);
         #1;
      end
      data_tready = 1'b1;
      send_beat(b2, 8'hFF, 1'b0, w);
      send_beat(64'h1112_1314_1516_1718, 8'hFF, 1'b0, w);
      send_beat(64'h2122_2324_2526_2728, 8'h01, 1'b1, w);
      idle_cycles(3);
      check_cnt("bp");

      // Malformed first beat: header not fully kept
      send_beat(mk(32'h8002_0000, 32'h0), 8'h07, 1'b0, w);
      send_beat(64'h0, 8'hFF, 1'b1, w);
      idle_cycles(2);
      check_cnt("malformed");

      // 16 accepted control packets saturate the 4-bit counter
      for (int i = 0; i < 16; i++)
         send_beat(mk(32'h8000_0000 | (32'(types[i % 7]) << 16), 32'(i)), 8'hFF, 1'b1, w);
      idle_cycles(3);
      check("cnt_ctrl_sat", 64'(cnt_ctrl), 64'hF);
      check_cnt("sat");

      // Clear coinciding with an increment
      clr_cnt = 1'b1;
      send_beat(mk(32'h8001_0000, 32'h0), 8'hFF, 1'b1, w);
      clr_cnt = 1'b0;
      check("clr_cnt_ctrl", 64'(cnt_ctrl), 64'd0);
      check_cnt("clr");
      send_beat(mk(32'h0000_0777, 32'h0), 8'hFF, 1'b1, w);
      idle_cycles(3);
      check_cnt("after_clr");

      // Reset mid-packet while a control beat is held
      ctrl_tready = 1'b0;
      send_beat(mk(32'h8001_0000, 32'h4444_4444), 8'hFF, 1'b0, w);
      check("held_ctrl_tvalid", 64'(ctrl_tvalid), 64'd1);
      in_tdata  = 64'hFFFF_FFFF_FFFF_FFFF;
      in_tvalid = 1'b1;
      #2 core_rst = 1'b1;
      #1;
      check("async_ctrl_tvalid", 64'(ctrl_tvalid), 64'd0);
      check("rst_mid_in_tready", 64'(in_tready), 64'd0);
      cq.delete();
      m_state = 0;
      e_data = 0; e_ctrl = 0; e_drop = 0;
      check_cnt("rst_mid");
      in_tvalid = 1'b0;
      @(posedge core_clk);
      #1;
      core_rst    = 1'b0;
      ctrl_tready = 1'b1;
      send_beat(mk(32'h8006_0000, 32'h6666_0000), 8'hFF, 1'b0, w);
      check("ack2_ctrl_type", 64'(ctrl_type), 64'd6);
      send_beat(64'h6666_6666_6666_6666, 8'hFF, 1'b1, w);
      idle_cycles(3);
      check_cnt("ack2");

      for (int i = 0; i < 50 && (dq.size() != 0 || cq.size() != 0); i++)
         idle_cycles(1);
      check("data_queue_drained", 64'(dq.size()), 64'd0);
      check("ctrl_queue_drained", 64'(cq.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
